// File: rtl/foobar_event_queue.sv
// Classifies enabled foo/bar steps into FOO/BAR/FOOBAR events, stamps them with a
// cycle counter and queues them for a valid/ready reader; overflowing events are counted.
module foobar_event_queue #(
  parameter int DEPTH   = 8,
  parameter int STAMP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     foo,
  input  logic                     bar,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_type,
  output logic [STAMP_W-1:0]       out_stamp,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]        FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]        LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0]      PTR_ONE    = AW'(1);
  localparam logic [STAMP_W-1:0] STAMP_ONE  = STAMP_W'(1);

  logic [1:0]         type_mem  [DEPTH];
  logic [STAMP_W-1:0] stamp_mem [DEPTH];

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [STAMP_W-1:0] stamp;
  logic [AW:0]        level_next;
  logic               event_hit;
  logic               pop;
  logic               push;
  logic               drop;

  assign event_hit = en & (foo | bar);
  assign pop       = out_valid & out_ready;
  // A full queue still accepts an event when the head leaves in the same cycle.
  assign push      = event_hit & ((level != FULL_LEVEL) | pop);
  assign drop      = event_hit & ~push;

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + LVL_ONE;
    else if (pop && !push)
      level_next = level - LVL_ONE;
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      type_mem[wr_ptr]  <= {bar, foo};
      stamp_mem[wr_ptr] <= stamp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      stamp      <= '0;
      level      <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      stamp      <= '0;
      level      <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (en)
        stamp <= stamp + STAMP_ONE;
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      level     <= level_next;
      out_valid <= (level_next != '0);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign out_type  = out_valid ? type_mem[rd_ptr]  : 2'b00;
  assign out_stamp = out_valid ? stamp_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_foobar_event_queue.sv
// Directed bench for foobar_event_queue: hand-computed event orders, overflow,
// saturation, stamp wrap, clear priority and asynchronous reset.
module tb_foobar_event_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, foo = 1'b0, bar = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic       out_valid;
  logic [1:0] out_type;
  logic [7:0] out_stamp;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] drop_count;

  int checks = 0;
  int passes = 0;
  int pops   = 0;
  logic [9:0] exp_q[$];

  foobar_event_queue #(.DEPTH(8), .STAMP_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .foo(foo), .bar(bar), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_stamp(out_stamp), .level(level), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs === expv) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  // One clock step: drive inputs, compare any pop at mid-cycle, then advance past the edge.
  task automatic cyc(input logic e, input logic f, input logic b, input logic r);
    logic [9:0] x;
    en = e; foo = f; bar = b; out_ready = r;
    #4;
    if (out_valid && out_ready && !clr) begin
      pops++;
      if (exp_q.size() == 0) check("unexpected_pop", 1, 0);
      else begin
        x = exp_q.pop_front();
        check("pop_type", 32'(out_type), 32'(x[9:8]));
        check("pop_stamp", 32'(out_stamp), 32'(x[7:0]));
        $display("pop type=%0d stamp=%0d", out_type, out_stamp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(0, 0, 0, 0);
    clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_type", 32'(out_type), 0);
    check("rst_stamp", 32'(out_stamp), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drop", 32'(drop_count), 0);
    rst = 1'b1;

    // 1: foo every 3rd step, bar every 5th, reader always ready
    exp_q = '{ {2'd3, 8'd0}, {2'd1, 8'd3}, {2'd2, 8'd5}, {2'd1, 8'd6},
               {2'd1, 8'd9}, {2'd2, 8'd10}, {2'd1, 8'd12}, {2'd3, 8'd15} };
    pops = 0;
    for (int i = 0; i < 16; i++) cyc(1, (i % 3) == 0, (i % 5) == 0, 1);
    repeat (3) cyc(0, 0, 0, 1);
    check("t1_pops", pops, 8);
    check("t1_drop", 32'(drop_count), 0);
    check("t1_level", 32'(level), 0);

    // 2: ten FOO events into a stalled reader
    do_clr();
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0);
    check("t2_level", 32'(level), 8);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_drop", 32'(drop_count), 2);
    check("t2_head_type", 32'(out_type), 1);
    check("t2_head_stamp", 32'(out_stamp), 0);

    // 3: full queue, event at stamp 10 while head pops
    exp_q = '{ {2'd1, 8'd0} };
    cyc(1, 1, 0, 1);
    check("t3_level", 32'(level), 8);
    check("t3_drop", 32'(drop_count), 2);
    exp_q = '{ {2'd1, 8'd1}, {2'd1, 8'd2}, {2'd1, 8'd3}, {2'd1, 8'd4},
               {2'd1, 8'd5}, {2'd1, 8'd6}, {2'd1, 8'd7}, {2'd1, 8'd10} };
    pops = 0;
    repeat (9) cyc(0, 0, 0, 1);
    check("t3_pops", pops, 8);
    check("t3_empty_valid", 32'(out_valid), 0);
    check("t3_empty_type", 32'(out_type), 0);

    // 4: 300 events, drop_count saturates
    do_clr();
    for (int i = 0; i < 300; i++) cyc(1, 1, 0, 0);
    check("t4_drop_sat", 32'(drop_count), 255);
    check("t4_level", 32'(level), 8);
    check("t4_ovf", 32'(overflow), 1);
    check("t4_head_stamp", 32'(out_stamp), 0);

    // 5a: en low ignores foo/bar and freezes stamp
    do_clr();
    repeat (5) cyc(0, 1, 1, 0);
    check("t5_noen_level", 32'(level), 0);
    check("t5_noen_valid", 32'(out_valid), 0);
    cyc(1, 1, 0, 0);
    check("t5_frozen_stamp", 32'(out_stamp), 0);
    check("t5_latency_valid", 32'(out_valid), 1);

    // 5b: stamp wraps 255 -> 0 -> 1
    do_clr();
    repeat (255) cyc(1, 0, 0, 0);
    check("t5_quiet_level", 32'(level), 0);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    exp_q = '{ {2'd2, 8'd255}, {2'd3, 8'd0}, {2'd1, 8'd1} };
    pops = 0;
    repeat (4) cyc(0, 0, 0, 1);
    check("t5_wrap_pops", pops, 3);

    // 6a: clr beats a same-cycle event with level=5, overflow=1
    do_clr();
    repeat (9) cyc(1, 1, 0, 0);
    exp_q = '{ {2'd1, 8'd0}, {2'd1, 8'd1}, {2'd1, 8'd2} };
    repeat (3) cyc(0, 0, 0, 1);
    check("t6_pre_level", 32'(level), 5);
    check("t6_pre_ovf", 32'(overflow), 1);
    clr = 1'b1;
    cyc(1, 1, 1, 0);
    clr = 1'b0;
    check("t6_clr_level", 32'(level), 0);
    check("t6_clr_valid", 32'(out_valid), 0);
    check("t6_clr_drop", 32'(drop_count), 0);
    check("t6_clr_ovf", 32'(overflow), 0);
    cyc(1, 1, 0, 0);
    check("t6_clr_stamp", 32'(out_stamp), 0);

    // 6b: asynchronous reset mid-drain
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 0);
    exp_q = '{ {2'd1, 8'd0} };
    cyc(0, 0, 0, 1);
    check("t6_pre_rst_level", 32'(level), 2);
    out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 0);
    check("t6_async_level", 32'(level), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(0, 0, 0, 1);
    check("t6_post_level", 32'(level), 0);
    check("t6_post_stamp", 32'(out_stamp), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
